music_tone_arbiter: RTL and testbench

- Sits between the tone sources and the tone generator that drives the buzzer.
- Arbitrates between two sources:
  - a UART-streamed tone source (pulse per byte);
  - a local sequencer that presents a note with a duration and expects an ack.
- Owns all note timing and drives a single registered music_tone bus to the tone generator.
- Handles stream end, stream timeout and pause.

---
 rtl/music_tone_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_music_tone_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/music_tone_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | music_tone_arbiter: arbitrates UART-streamed and sequencer notes, owns     |
// | note timing. Optional MUSIC_MIN_HOLD_EN defers UART preemption of a note.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module music_tone_arbiter #(
  parameter int         TICK_DIV        = 50000,
  parameter logic [7:0] SILENCE_CODE    = 8'd22,
  parameter int         UART_TIMEOUT_MS = 1000
`ifdef MUSIC_MIN_HOLD_EN
  , parameter int       MIN_HOLD_MS     = 20
`endif
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        uart_req,
  input  logic [7:0]  uart_tone,
  input  logic        local_req,
  input  logic [7:0]  local_tone,
  input  logic [15:0] local_dur_ms,
  output logic        local_ack,
  input  logic        pause,
  output logic [7:0]  music_tone,
  output logic [1:0]  tone_src,
  output logic        uart_idle,
  output logic        local_abort,
  output logic        timeout_flag
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCAL = 2'd1,
    ST_UART  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0] ms_q, ms_d;
  logic [15:0] dur_q, dur_d;
  logic [7:0]  tone_q, tone_d;
  logic [7:0]  music_tone_q, music_tone_d;
  logic [1:0]  tone_src_q, tone_src_d;
  logic        uart_idle_q, uart_idle_d;
  logic        local_ack_q, local_ack_d;
  logic        local_abort_q, local_abort_d;
  logic        timeout_flag_q, timeout_flag_d;
`ifdef MUSIC_MIN_HOLD_EN
  logic        pend_valid_q, pend_valid_d;
  logic [7:0]  pend_tone_q, pend_tone_d;
  logic [15:0] hold_ms;
  logic        hold_met;
`endif

  logic        tick, uart_go, note_end, timeout_hit, accept;
  logic [15:0] dur_eff;

  always_comb begin
    tick        = !pause && (presc_q == PW'(TICK_DIV - 1));
    uart_go     = uart_req && (uart_tone != SILENCE_CODE);
    note_end    = (state_q == ST_LOCAL) && tick && (ms_q == dur_q - 16'd1);
    timeout_hit = (state_q == ST_UART) && tick && (ms_q == 16'(UART_TIMEOUT_MS - 1));
    dur_eff     = (local_dur_ms == 16'd0) ? 16'd1 : local_dur_ms;

    state_d        = state_q;
    tone_d         = tone_q;
    dur_d          = dur_q;
    local_ack_d    = 1'b0;
    local_abort_d  = 1'b0;
    timeout_flag_d = 1'b0;
    accept         = 1'b0;
`ifdef MUSIC_MIN_HOLD_EN
    hold_ms      = (dur_q < 16'(MIN_HOLD_MS)) ? dur_q : 16'(MIN_HOLD_MS);
    hold_met     = (ms_q >= hold_ms) || (tick && (ms_q + 16'd1 >= hold_ms));
    pend_valid_d = pend_valid_q;
    pend_tone_d  = pend_tone_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (uart_go) begin
          state_d = ST_UART;
          tone_d  = uart_tone;
          accept  = 1'b1;
        end else if (local_req && !pause) begin
          state_d     = ST_LOCAL;
          tone_d      = local_tone;
          dur_d       = dur_eff;
          local_ack_d = 1'b1;
          accept      = 1'b1;
        end
      end
      ST_LOCAL: begin
`ifdef MUSIC_MIN_HOLD_EN
        // Pending byte is armed only by a non-silence code; once armed, any byte overwrites it.
        if (uart_req && (pend_valid_q || uart_go)) begin
          pend_valid_d = 1'b1;
          pend_tone_d  = uart_tone;
        end
        if (pend_valid_d && hold_met) begin
          pend_valid_d  = 1'b0;
          local_abort_d = !note_end;
          if (pend_tone_d == SILENCE_CODE) begin
            state_d = ST_IDLE;
            tone_d  = SILENCE_CODE;
          end else begin
            state_d = ST_UART;
            tone_d  = pend_tone_d;
            accept  = 1'b1;
          end
        end else
`else
        if (uart_go) begin
          state_d       = ST_UART;
          tone_d        = uart_tone;
          local_abort_d = 1'b1;
          accept        = 1'b1;
        end else
`endif
        if (note_end) begin
          if (local_req) begin
            tone_d      = local_tone;
            dur_d       = dur_eff;
            local_ack_d = 1'b1;
            accept      = 1'b1;
          end else begin
            state_d = ST_IDLE;
            tone_d  = SILENCE_CODE;
          end
        end
      end
      ST_UART: begin
        if (uart_req) begin
          if (uart_tone == SILENCE_CODE) begin
            state_d = ST_IDLE;
            tone_d  = SILENCE_CODE;
          end else begin
            tone_d = uart_tone;
            accept = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d        = ST_IDLE;
          tone_d         = SILENCE_CODE;
          timeout_flag_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tone_d  = SILENCE_CODE;
      end
    endcase

`ifdef MUSIC_MIN_HOLD_EN
    if (state_d != ST_LOCAL) pend_valid_d = 1'b0;
`endif

    // Timing restarts on every acceptance and sits at zero while idle.
    if (accept || (state_d == ST_IDLE)) begin
      presc_d = '0;
      ms_d    = 16'd0;
    end else if (pause) begin
      presc_d = presc_q;
      ms_d    = ms_q;
    end else if (tick) begin
      presc_d = '0;
      ms_d    = ms_q + 16'd1;
    end else begin
      presc_d = presc_q + PW'(1);
      ms_d    = ms_q;
    end

    music_tone_d = pause ? SILENCE_CODE : tone_d;
    tone_src_d   = state_d;
    uart_idle_d  = (state_d != ST_UART);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q        <= ST_IDLE;
      presc_q        <= '0;
      ms_q           <= 16'd0;
      dur_q          <= 16'd0;
      tone_q         <= SILENCE_CODE;
      music_tone_q   <= SILENCE_CODE;
      tone_src_q     <= 2'd0;
      uart_idle_q    <= 1'b1;
      local_ack_q    <= 1'b0;
      local_abort_q  <= 1'b0;
      timeout_flag_q <= 1'b0;
`ifdef MUSIC_MIN_HOLD_EN
      pend_valid_q   <= 1'b0;
      pend_tone_q    <= 8'd0;
`endif
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      ms_q           <= ms_d;
      dur_q          <= dur_d;
      tone_q         <= tone_d;
      music_tone_q   <= music_tone_d;
      tone_src_q     <= tone_src_d;
      uart_idle_q    <= uart_idle_d;
      local_ack_q    <= local_ack_d;
      local_abort_q  <= local_abort_d;
      timeout_flag_q <= timeout_flag_d;
`ifdef MUSIC_MIN_HOLD_EN
      pend_valid_q   <= pend_valid_d;
      pend_tone_q    <= pend_tone_d;
`endif
    end
  end

  assign music_tone   = music_tone_q;
  assign tone_src     = tone_src_q;
  assign uart_idle    = uart_idle_q;
  assign local_ack    = local_ack_q;
  assign local_abort  = local_abort_q;
  assign timeout_flag = timeout_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_music_tone_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_music_tone_arbiter: directed vectors and corner sequences for the       |
// | tone arbiter (TICK_DIV = 10, UART_TIMEOUT_MS = 5).                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_music_tone_arbiter;

  localparam int         TICK_DIV = 10;
  localparam logic [7:0] SIL      = 8'd22;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        uart_req = 1'b0;
  logic [7:0]  uart_tone = 8'd0;
  logic        local_req = 1'b0;
  logic [7:0]  local_tone = 8'd0;
  logic [15:0] local_dur_ms = 16'd0;
  logic        pause = 1'b0;
  logic        local_ack, uart_idle, local_abort, timeout_flag;
  logic [7:0]  music_tone;
  logic [1:0]  tone_src;

  music_tone_arbiter #(
    .TICK_DIV        (TICK_DIV),
    .SILENCE_CODE    (SIL),
    .UART_TIMEOUT_MS (5)
`ifdef MUSIC_MIN_HOLD_EN
    , .MIN_HOLD_MS   (2)
`endif
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .uart_req     (uart_req),
    .uart_tone    (uart_tone),
    .local_req    (local_req),
    .local_tone   (local_tone),
    .local_dur_ms (local_dur_ms),
    .local_ack    (local_ack),
    .pause        (pause),
    .music_tone   (music_tone),
    .tone_src     (tone_src),
    .uart_idle    (uart_idle),
    .local_abort  (local_abort),
    .timeout_flag (timeout_flag)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [7:0]  tone;
    logic [15:0] dur;
    logic [7:0]  exp_tone;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[4];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic send_uart(input logic [7:0] code);
    uart_tone = code;
    uart_req  = 1'b1;
    step();
    uart_req  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int cnt;
    local_tone   = v.tone;
    local_dur_ms = v.dur;
    local_req    = 1'b1;
    step();
    chk("vec_ack", int'(local_ack), 1);
    chk("vec_tone", int'(music_tone), int'(v.exp_tone));
    chk("vec_src", int'(tone_src), 1);
    local_req = 1'b0;
    cnt = 1;
    step();
    while (music_tone == v.exp_tone && cnt < 1000) begin
      cnt++;
      step();
    end
    chk("vec_len", cnt, v.exp_cycles);
    chk("vec_end_tone", int'(music_tone), int'(SIL));
    chk("vec_end_src", int'(tone_src), 0);
  endtask

  initial begin
    int cnt;
    int acks;
    int gaps;

    vecs[0] = '{tone: 8'd6,   dur: 16'd3, exp_tone: 8'd6,   exp_cycles: 30};
    vecs[1] = '{tone: 8'd5,   dur: 16'd0, exp_tone: 8'd5,   exp_cycles: 10};
    vecs[2] = '{tone: 8'd11,  dur: 16'd1, exp_tone: 8'd11,  exp_cycles: 10};
    vecs[3] = '{tone: 8'd200, dur: 16'd2, exp_tone: 8'd200, exp_cycles: 20};

    // Reset state
    repeat (3) step();
    sys_rst = 1'b0;
    step();
    chk("rst_tone", int'(music_tone), int'(SIL));
    chk("rst_src", int'(tone_src), 0);
    chk("rst_uart_idle", int'(uart_idle), 1);
    chk("rst_pulses", int'({local_ack, local_abort, timeout_flag}), 0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Back-to-back local notes: 7 for 2 ms then 8 for 1 ms, no silent gap
    local_tone = 8'd7; local_dur_ms = 16'd2; local_req = 1'b1;
    step();
    chk("b2b_ack1", int'(local_ack), 1);
    chk("b2b_tone1", int'(music_tone), 7);
    local_tone = 8'd8; local_dur_ms = 16'd1;
    cnt = 0; gaps = 0;
    do begin
      step();
      cnt++;
      if (music_tone == SIL) gaps++;
    end while (!local_ack && cnt < 200);
    chk("b2b_ack_gap", cnt, 20);
    chk("b2b_silent_cycles", gaps, 0);
    chk("b2b_tone2", int'(music_tone), 8);
    local_req = 1'b0;
    repeat (10) step();
    chk("b2b_end_tone", int'(music_tone), int'(SIL));

    // UART stream 12, 13, then end-of-stream
    send_uart(8'd12);
    chk("uart_tone12", int'(music_tone), 12);
    chk("uart_src", int'(tone_src), 2);
    chk("uart_busy", int'(uart_idle), 0);
    repeat (3) step();
    send_uart(8'd13);
    chk("uart_tone13", int'(music_tone), 13);
    send_uart(SIL);
    chk("uart_end_tone", int'(music_tone), int'(SIL));
    chk("uart_end_src", int'(tone_src), 0);
    chk("uart_end_idle", int'(uart_idle), 1);

    // UART timeout: 5 ms of silence after byte 9
    send_uart(8'd9);
    chk("to_tone", int'(music_tone), 9);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!timeout_flag && cnt < 500);
    chk("to_latency", cnt, 50);
    chk("to_tone_silent", int'(music_tone), int'(SIL));
    chk("to_uart_idle", int'(uart_idle), 1);
    step();
    chk("to_pulse_width", int'(timeout_flag), 0);

    // UART byte 4 arriving 12 cycles into local note (10, 5 ms)
    local_tone = 8'd10; local_dur_ms = 16'd5; local_req = 1'b1;
    step();
    chk("pre_ack", int'(local_ack), 1);
    local_req = 1'b0;
    repeat (11) step();
    send_uart(8'd4);
`ifdef MUSIC_MIN_HOLD_EN
    chk("pre_held_tone", int'(music_tone), 10);
    chk("pre_held_abort", int'(local_abort), 0);
    repeat (7) step();
    chk("pre_hold_last", int'(music_tone), 10);
    step();
`endif
    chk("pre_abort", int'(local_abort), 1);
    chk("pre_tone", int'(music_tone), 4);
    chk("pre_src", int'(tone_src), 2);
    step();
    chk("pre_abort_width", int'(local_abort), 0);
    send_uart(SIL);

    // Pause for 15 cycles inside a 3 ms local note
    local_tone = 8'd15; local_dur_ms = 16'd3; local_req = 1'b1;
    step();
    local_req = 1'b0;
    cnt = 1;
    while (tone_src == 2'd1 && cnt < 500) begin
      if (cnt == 10) pause = 1'b1;
      if (cnt == 25) pause = 1'b0;
      step();
      cnt++;
      if (cnt == 18) chk("pause_silent", int'(music_tone), int'(SIL));
      if (cnt == 27) chk("pause_resume", int'(music_tone), 15);
    end
    chk("pause_note_len", cnt - 1, 45);
    chk("pause_end_tone", int'(music_tone), int'(SIL));

    // Simultaneous UART and local request from idle: UART wins
    local_tone = 8'd5; local_dur_ms = 16'd1; local_req = 1'b1;
    send_uart(8'd3);
    chk("race_src", int'(tone_src), 2);
    chk("race_tone", int'(music_tone), 3);
    acks = int'(local_ack);
    repeat (5) begin
      step();
      acks += int'(local_ack);
    end
    local_req = 1'b0;
    send_uart(SIL);
    acks += int'(local_ack);
    chk("race_no_ack", acks, 0);
    chk("race_end_src", int'(tone_src), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
